fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller for the single-cycle datapath. It owns the program counter and drives the byte address of the combinational instruction ROM. It presents each fetched instruction with its PC to the decode stage over a valid/ready handshake. It also handles stall back-pressure, branch/jump redirects, and a halt instruction that freezes fetch until resumed.

## Interface
- ADDR_W, 32, PC width in bits
- ROM_AW, 6, byte-address bits driven to the instruction ROM
- RESET_PC, 32'h0000_0000, PC loaded on reset
- HALT_INSTR, 32'hFFFF_FFFF, instruction encoding that halts fetch

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- imem_addr  out  ROM_AW  ROM byte address; equals pc[ROM_AW-1:0]
- imem_data  in  32  ROM read data, combinational from imem_addr
- out_valid  out  1  out_instr/out_pc hold a fetched instruction
- out_ready  in  1  decode accepts the instruction this cycle
- out_instr  out  32  fetched instruction
- out_pc  out  ADDR_W  byte address of out_instr
- redirect_valid  in  1  branch/jump taken; single-cycle pulse or level
- redirect_pc  in  ADDR_W  redirect target
- resume  in  1  leave HALT
- halted  out  1  state is HALT
- perf_fetched  out  32  accepted-instruction count (see Configuration)
- perf_stalls  out  32  stall-cycle count (see Configuration)

## Operation
- Registers: pc, output register (out_valid, out_instr, out_pc), state ∈ {FETCH, HALT}.
- Reset (reset=0, immediate, async):
  - pc=RESET_PC; state=FETCH.
  - out_valid=0; out_instr=0; out_pc=0; halted=0.
  - Perf counters=0.
- load condition: state==FETCH && (!out_valid || out_ready) && !redirect_valid.
- On load:
  - out_instr<=imem_data; out_pc<=pc; out_valid<=1; pc<=pc+4.
- Hold: out_valid && !out_ready in FETCH → all registers unchanged (stall).
- Accept without load (HALT state): out_valid && out_ready → out_valid<=0.
- Redirect, highest priority, any state:
  - pc<=redirect_pc with bits [1:0] forced to 0.
  - out_valid<=0, which flushes any unaccepted instruction.
  - state<=FETCH.
  - An instruction with out_valid && out_ready in the same cycle counts as accepted.
- Halt: a load whose imem_data==HALT_INSTR sets state<=HALT at the same edge.
  - The halt instruction is still presented and must be accepted.
  - pc holds halt address+4.
  - No loads occur in HALT.
- resume in HALT → state<=FETCH next edge. resume in FETCH is ignored.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W. imem_addr wraps modulo 2^ROM_AW (16-word ROM at ROM_AW=6).

## Timing
- Fetch latency: instruction at pc is visible on out_instr 1 cycle after the load edge.
- Throughput: 1 instruction/cycle while out_ready=1.
- First edge with reset=1 loads the instruction at RESET_PC. out_valid rises after that edge.
- Redirect: edge N samples redirect_valid. out_valid=0 during cycle N+1. Edge N+1 loads the target, so out_pc=target from cycle N+2.
- Redirect penalty: 1 bubble.
- halted rises the cycle after the halt load edge. After resume, the next load occurs at the edge following the HALT→FETCH edge.
- out_* are stable while out_valid && !out_ready.

## Configuration
- FETCH_CTRL_PERF_EN defined:
  - perf_fetched increments on each out_valid && out_ready.
  - perf_stalls increments on each cycle with out_valid && !out_ready.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Not defined: both ports are tied to 32'h0 and no counter flops are instantiated.

## Test plan
- Reset release, out_ready=1, ROM words 0..3 = A,B,C,D → out_pc 0,4,8,12 on consecutive cycles with out_instr A..D. imem_addr cycles 0→4→8→12.
- out_ready=0 for 3 cycles while out_pc=4 → out_pc/out_instr are held. pc stays 8. perf_stalls=3 with FETCH_CTRL_PERF_EN.
- redirect_valid with redirect_pc=0x23 while out_pc=8 is unaccepted → one cycle with out_valid=0, then out_pc=0x20.
- ROM word 2 = 32'hFFFF_FFFF → halt word is delivered with out_pc=8, halted=1, and no further valid output. resume → next out_pc=12.
- Sequential wrap, ROM_AW=6: after out_pc=0x3C, imem_addr=0 and out_pc=0x40 with out_instr = word 0.
- reset asserted mid-stall with out_valid=1 → out_valid=0 and halted=0 immediately, without waiting for a clock edge. After release, the first out_pc is RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller. Owns the PC, addresses the
// combinational instruction ROM and hands each fetched word with its PC to
// decode over a valid/ready handshake. Handles stalls, redirects and halt.
// Optional performance counters are enabled by defining FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
    parameter int          ADDR_W     = 32,
    parameter int          ROM_AW     = 6,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ROM_AW-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              resume,
    output logic              halted,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stalls
);

    typedef enum logic {S_FETCH = 1'b0, S_HALT = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;

    logic accept, stall, load;

    assign accept = out_valid_q && out_ready;
    assign stall  = out_valid_q && !out_ready;
    assign load   = (state_q == S_FETCH) && (!out_valid_q || out_ready) && !redirect_valid;

    assign imem_addr = pc_q[ROM_AW-1:0];
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign halted    = (state_q == S_HALT);

    // Next-state: redirect beats load, load beats plain accept; resume leaves HALT.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        if (redirect_valid) begin
            // Word-align the target; any unaccepted instruction is flushed.
            pc_d        = redirect_pc & ~ADDR_W'(3);
            out_valid_d = 1'b0;
            state_d     = S_FETCH;
        end else if (load) begin
            out_instr_d = imem_data;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + ADDR_W'(4);
            if (imem_data == HALT_INSTR)
                state_d = S_HALT;
        end else begin
            if (accept)
                out_valid_d = 1'b0;
            if (state_q == S_HALT && resume)
                state_d = S_FETCH;
        end
    end

    // State, PC and output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            pc_q        <= ADDR_W'(RESET_PC);
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] stalls_q, stalls_d;

    // Saturating increments: accepted handshakes and back-pressured cycles.
    always_comb begin
        fetched_d = fetched_q;
        stalls_d  = stalls_q;
        if (accept && fetched_q != 32'hFFFF_FFFF)
            fetched_d = fetched_q + 32'd1;
        if (stall && stalls_q != 32'hFFFF_FFFF)
            stalls_d = stalls_q + 32'd1;
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetched_q <= '0;
            stalls_q  <= '0;
        end else begin
            fetched_q <= fetched_d;
            stalls_q  <= stalls_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stalls  = stalls_q;
`else
    assign perf_fetched = 32'h0;
    assign perf_stalls  = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vectors for fetch_ctrl with a 16-word ROM model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        resume;
    logic        halted;
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;

    logic [31:0] rom [16];
    int n_cmp = 0;
    int n_err = 0;

    assign imem_data = rom[4'(imem_addr >> 2)];

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .resume         (resume),
        .halted         (halted),
        .perf_fetched   (perf_fetched),
        .perf_stalls    (perf_stalls)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, release it just after an edge.
    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 32'hA000_0000 + 32'(i);
        reset          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        resume         = 1'b0;
        #1;
        chk("rst_valid",   out_valid, 0);
        chk("rst_halted",  halted, 0);
        chk("rst_pc",      out_pc, 0);
        chk("rst_instr",   out_instr, 0);
        chk("rst_addr",    imem_addr, 0);
        chk("rst_pfetch",  perf_fetched, 0);
        chk("rst_pstall",  perf_stalls, 0);

        // Streaming fetch, words 0..3
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("seq_valid", out_valid, 1);
            chk("seq_pc",    out_pc, 64'(4 * k));
            chk("seq_instr", out_instr, 64'(32'hA000_0000 + 32'(k)));
            chk("seq_addr",  imem_addr, 64'((4 * k + 4) % 64));
        end

        // Stall 3 cycles while out_pc=4
        do_reset();
        step();
        step();
        chk("stl_pre_pc", out_pc, 4);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stl_pc",    out_pc, 4);
            chk("stl_instr", out_instr, 32'hA000_0001);
            chk("stl_valid", out_valid, 1);
            chk("stl_addr",  imem_addr, 8);
        end
`ifdef FETCH_CTRL_PERF_EN
        chk("stl_pstall",  perf_stalls, 3);
        chk("stl_pfetch",  perf_fetched, 1);
`else
        chk("stl_pstall",  perf_stalls, 0);
        chk("stl_pfetch",  perf_fetched, 0);
`endif
        out_ready = 1'b1;
        step();
        chk("stl_post_pc", out_pc, 8);

        // Redirect to 0x23 while out_pc=8 is unaccepted
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h23;
        step();
        chk("rdr_bubble", out_valid, 0);
        chk("rdr_addr",   imem_addr, 6'h20);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        step();
        chk("rdr_valid", out_valid, 1);
        chk("rdr_pc",    out_pc, 32'h20);
        chk("rdr_instr", out_instr, 32'hA000_0008);

        // Halt at word 2, then resume
        rom[2] = 32'hFFFF_FFFF;
        do_reset();
        step();
        step();
        step();
        chk("hlt_pc",     out_pc, 8);
        chk("hlt_instr",  out_instr, 32'hFFFF_FFFF);
        chk("hlt_halted", halted, 1);
        step();
        chk("hlt_drain",  out_valid, 0);
        chk("hlt_addr",   imem_addr, 12);
        step();
        chk("hlt_idle",   out_valid, 0);
        chk("hlt_still",  halted, 1);
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("rsm_halted", halted, 0);
        chk("rsm_valid",  out_valid, 0);
        step();
        chk("rsm_valid2", out_valid, 1);
        chk("rsm_pc",     out_pc, 12);
        chk("rsm_instr",  out_instr, 32'hA000_0003);
        rom[2] = 32'hA000_0002;

        // ROM address wrap
        do_reset();
        for (int k = 0; k < 16; k++) step();
        chk("wrp_pc0",   out_pc, 32'h3C);
        chk("wrp_addr",  imem_addr, 0);
        step();
        chk("wrp_pc",    out_pc, 32'h40);
        chk("wrp_instr", out_instr, 32'hA000_0000);

        // Asynchronous reset mid-stall
        do_reset();
        step();
        step();
        out_ready = 1'b0;
        step();
        chk("ars_pre", out_valid, 1);
        reset = 1'b0;
        #1;
        chk("ars_valid",  out_valid, 0);
        chk("ars_halted", halted, 0);
        chk("ars_pc",     out_pc, 0);
        step();
        reset     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("ars_first_valid", out_valid, 1);
        chk("ars_first_pc",    out_pc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
